// File: rtl/reg6502_pkg.sv
// Shared types and constants for the 6502 register-load and future ALU sequencers.
// Holds the FSM state enum, the supported opcode set and the mux/address select codes.
package reg6502_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_DECODE,
    ST_OPER_LO,
    ST_OPER_HI,
    ST_READ,
    ST_WB,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    CLS_IMM,
    CLS_ZP,
    CLS_ABS,
    CLS_XFER
  } addr_cls_t;

  typedef enum logic [1:0] {
    DST_NONE,
    DST_A,
    DST_X,
    DST_Y
  } dst_t;

  typedef struct packed {
    addr_cls_t  cls;
    dst_t       dst;
    logic [1:0] src;
    logic       legal;
  } dec_t;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_TXA     = 8'h8A;
  localparam logic [7:0] OP_TAY     = 8'hA8;
  localparam logic [7:0] OP_TYA     = 8'h98;

  localparam logic [1:0] SRC_MEM = 2'd0;
  localparam logic [1:0] SRC_A   = 2'd1;
  localparam logic [1:0] SRC_X   = 2'd2;
  localparam logic [1:0] SRC_Y   = 2'd3;

  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_ZP  = 2'd1;
  localparam logic [1:0] ADDR_ABS = 2'd2;

  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_OPER_LO) || (s == ST_OPER_HI) || (s == ST_READ);
  endfunction

endpackage

// File: rtl/reg_load_sequencer_if.sv
// Memory read handshake between the load sequencer and the memory/PC block.
// master = sequencer side, slave = memory side.
interface reg_load_sequencer_if;
  logic [7:0] mem_data;
  logic       mem_ack;
  logic       mem_req;
  logic [1:0] addr_sel;
  logic       pc_inc;

  modport master (
    output mem_req, addr_sel, pc_inc,
    input  mem_data, mem_ack
  );

  modport slave (
    input  mem_req, addr_sel, pc_inc,
    output mem_data, mem_ack
  );
endinterface

// File: rtl/reg_load_decode.sv
// Opcode classifier: addressing class, destination register, mux source, legality.
// Latency: purely combinational.
// Backpressure: none, no handshake.
module reg_load_decode
  import reg6502_pkg::*;
(
  input  logic [7:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec = '{cls: CLS_XFER, dst: DST_NONE, src: SRC_MEM, legal: 1'b0};
    case (opcode)
      OP_LDA_IMM: dec = '{cls: CLS_IMM,  dst: DST_A, src: SRC_MEM, legal: 1'b1};
      OP_LDX_IMM: dec = '{cls: CLS_IMM,  dst: DST_X, src: SRC_MEM, legal: 1'b1};
      OP_LDY_IMM: dec = '{cls: CLS_IMM,  dst: DST_Y, src: SRC_MEM, legal: 1'b1};
      OP_LDA_ZP:  dec = '{cls: CLS_ZP,   dst: DST_A, src: SRC_MEM, legal: 1'b1};
      OP_LDA_ABS: dec = '{cls: CLS_ABS,  dst: DST_A, src: SRC_MEM, legal: 1'b1};
      OP_TAX:     dec = '{cls: CLS_XFER, dst: DST_X, src: SRC_A,   legal: 1'b1};
      OP_TAY:     dec = '{cls: CLS_XFER, dst: DST_Y, src: SRC_A,   legal: 1'b1};
      OP_TXA:     dec = '{cls: CLS_XFER, dst: DST_A, src: SRC_X,   legal: 1'b1};
      OP_TYA:     dec = '{cls: CLS_XFER, dst: DST_A, src: SRC_Y,   legal: 1'b1};
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_load_sequencer.sv
// Micro-sequencer for the A/X/Y load paths: fetch, operand/read cycles, one-cycle load strobes.
// Latency (zero-wait memory): transfer 3, imm 4, zp 5, abs 6 cycles from FETCH to WB.
// Backpressure: each memory state holds mem_req until mem_ack; TIMEOUT unacked cycles -> FAULT.
module reg_load_sequencer
  import reg6502_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 FSM_Signal,
  input  logic                 reset_n,
  reg_load_sequencer_if.master mem,
  output logic [1:0]           src_sel,
  output logic                 load_A,
  output logic                 load_X,
  output logic                 load_Y,
  output logic                 reset_A,
  output logic                 reset_X,
  output logic                 reset_Y,
  output logic                 load_NZ,
  output logic [7:0]           opl,
  output logic [7:0]           oph,
  output logic [7:0]           ir,
  output logic [7:0]           data_latch,
  output logic                 illegal,
  output logic                 bus_err
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  dec_t       dec;
  logic       mem_phase, acked, timed_out;

  reg_load_decode u_decode (
    .opcode (ir),
    .dec    (dec)
  );

  // An ack outside a memory state is meaningless and must not move the FSM.
  assign mem_phase = is_mem_state(state);
  assign acked     = mem_phase && mem.mem_ack;
  assign timed_out = mem_phase && !mem.mem_ack && (wait_cnt == WAIT_LAST);

  always_ff @(posedge FSM_Signal or negedge reset_n) begin
    if (!reset_n) state <= ST_INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:    state_nxt = ST_FETCH;
      ST_FETCH:   if (acked) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (!dec.legal)              state_nxt = ST_FETCH;
        else if (dec.cls == CLS_XFER) state_nxt = ST_WB;
        else                          state_nxt = ST_OPER_LO;
      end
      ST_OPER_LO: begin
        if (acked) begin
          case (dec.cls)
            CLS_IMM: state_nxt = ST_WB;
            CLS_ZP:  state_nxt = ST_READ;
            default: state_nxt = ST_OPER_HI;
          endcase
        end
      end
      ST_OPER_HI: if (acked) state_nxt = ST_READ;
      ST_READ:    if (acked) state_nxt = ST_WB;
      ST_WB:      state_nxt = ST_FETCH;
      default:    state_nxt = state;
    endcase
    if (timed_out) state_nxt = ST_FAULT;
  end

  always_ff @(posedge FSM_Signal or negedge reset_n) begin
    if (!reset_n) begin
      ir         <= 8'h00;
      opl        <= 8'h00;
      oph        <= 8'h00;
      data_latch <= 8'h00;
      wait_cnt   <= 8'h00;
      illegal    <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      // Any state change starts a fresh wait window; staying in a memory state means no ack.
      if (state_nxt != state) wait_cnt <= 8'h00;
      else if (mem_phase)     wait_cnt <= wait_cnt + 8'd1;

      if (state == ST_FETCH && acked) ir <= mem.mem_data;
      if (state == ST_OPER_LO && acked) begin
        opl        <= mem.mem_data;
        data_latch <= mem.mem_data;
      end
      if (state == ST_OPER_HI && acked) oph <= mem.mem_data;
      if (state == ST_READ && acked) data_latch <= mem.mem_data;
      if (state == ST_DECODE && !dec.legal) illegal <= 1'b1;
      if (timed_out) bus_err <= 1'b1;
    end
  end

  // Gated by reset_n so every strobe drops the moment reset is asserted, INIT included.
  always_comb begin
    mem.mem_req  = 1'b0;
    mem.addr_sel = ADDR_PC;
    mem.pc_inc   = 1'b0;
    src_sel      = SRC_MEM;
    load_A       = 1'b0;
    load_X       = 1'b0;
    load_Y       = 1'b0;
    reset_A      = 1'b0;
    reset_X      = 1'b0;
    reset_Y      = 1'b0;
    load_NZ      = 1'b0;
    if (reset_n) begin
      case (state)
        ST_INIT: begin
          reset_A = 1'b1;
          reset_X = 1'b1;
          reset_Y = 1'b1;
        end
        ST_FETCH, ST_OPER_LO, ST_OPER_HI: begin
          mem.mem_req = 1'b1;
          mem.pc_inc  = mem.mem_ack;
        end
        ST_READ: begin
          mem.mem_req  = 1'b1;
          mem.addr_sel = (dec.cls == CLS_ABS) ? ADDR_ABS : ADDR_ZP;
        end
        ST_WB: begin
          load_NZ = 1'b1;
          src_sel = dec.src;
          case (dec.dst)
            DST_A:   load_A = 1'b1;
            DST_X:   load_X = 1'b1;
            DST_Y:   load_Y = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/reg_load_sequencer.md
Name: reg_load_sequencer

Overview:
Micro-sequencer for the 6502 core's A, X and Y register load paths. It fetches an opcode, walks the operand and read cycles for a supported load/transfer subset, and emits one-cycle load_A/load_X/load_Y and reset_A/X/Y strobes to the register blocks. It also drives the source mux select, the address-source select and the memory read handshake. It sits between the memory interface and the A/X/Y register instances, all clocked by FSM_Signal.

Parameters:
TIMEOUT, 15, maximum FSM_Signal cycles spent waiting for mem_ack before FAULT (1..255)

Ports:
FSM_Signal  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
mem_data  in  8  read data from memory, valid while mem_ack=1
mem_ack  in  1  memory read complete for the current mem_req
mem_req  out  1  memory read request, held until ack
addr_sel  out  2  0=PC, 1=zero-page {8'h00,OPL}, 2=absolute {OPH,OPL}
pc_inc  out  1  increment PC (1-cycle pulse)
src_sel  out  2  register input mux: 0=mem_data latch, 1=A, 2=X, 3=Y
load_A / load_X / load_Y  out  1 each  register load strobes
reset_A / reset_X / reset_Y  out  1 each  register clear strobes (common value)
load_NZ  out  1  update N/Z flags from the mux output
opl / oph  out  8 each  operand-byte latches, feeding the address generator
ir  out  8  latched opcode
illegal  out  1  sticky: unsupported opcode seen
bus_err  out  1  sticky: ack timeout

Behaviour:
- Reset (reset_n=0, async): state=INIT; ir, opl, oph and the data latch =8'h00; wait counter=0; illegal=bus_err=0; every strobe output=0.
- States: INIT, FETCH, DECODE, OPER_LO, OPER_HI, READ, WB, FAULT.
- Outputs are decoded from the registered state (Moore). Strobes are high for exactly one cycle. The register captures on the next FSM_Signal edge.
- INIT (1 cycle): reset_A=reset_X=reset_Y=1 -> FETCH.
- FETCH: mem_req=1, addr_sel=0. On mem_ack: ir<=mem_data, pc_inc=1 -> DECODE.
- DECODE (1 cycle), by opcode:
  - A9/A2/A0 (imm) -> OPER_LO.
  - A5 (zp), AD (abs) -> OPER_LO.
  - AA/8A/A8/98 (transfer) -> WB.
  - Any other opcode: illegal<=1 -> FETCH, with no strobes.
- OPER_LO: mem_req=1, addr_sel=0. On ack: opl<=mem_data, pc_inc=1, and data latch<=mem_data. Next state is WB for imm, READ for zp, OPER_HI for abs.
- OPER_HI: mem_req=1, addr_sel=0. On ack: oph<=mem_data, pc_inc=1 -> READ.
- READ: mem_req=1, addr_sel=1 (zp) or 2 (abs). On ack: data latch<=mem_data -> WB.
- WB (1 cycle): load_NZ=1, then -> FETCH. Per opcode:
  - A9/A5/AD: src_sel=0, load_A.
  - A2: src_sel=0, load_X.
  - A0: src_sel=0, load_Y.
  - AA: src_sel=1, load_X.
  - A8: src_sel=1, load_Y.
  - 8A: src_sel=2, load_A.
  - 98: src_sel=3, load_A.
- Latency with zero-wait ack (ack in the same cycle as req):
  - transfer: 3 cycles
  - imm: 4 cycles
  - zp: 5 cycles
  - abs: 6 cycles
- Wait counter:
  - Cleared on entry to each memory state.
  - Increments each cycle mem_req=1 and mem_ack=0.
  - Reaching TIMEOUT -> FAULT, bus_err<=1.
- FAULT: all strobes 0, mem_req=0. Left only by reset.
- mem_ack while mem_req=0 is ignored.
- Reset mid-instruction aborts immediately: no strobes follow, and INIT re-clears the registers.
- illegal and bus_err are cleared only by reset.

Decomposition:
- Shared package reg6502_pkg holds:
  - state enum
  - opcode constants (OP_LDA_IMM=8'hA9, OP_LDA_ZP=8'hA5, OP_LDA_ABS=8'hAD, OP_LDX_IMM=8'hA2, OP_LDY_IMM=8'hA0, OP_TAX=8'hAA, OP_TXA=8'h8A, OP_TAY=8'hA8, OP_TYA=8'h98)
  - SRC_MEM/SRC_A/SRC_X/SRC_Y and ADDR_PC/ADDR_ZP/ADDR_ABS codes
- One natural sub-module: reg_load_decode. It is a combinational mapping from opcode to {addressing class, destination, src_sel, legal}, reused by the future ALU sequencer.

Test Plan:
- Reset released, zero-wait memory -> INIT cycle with reset_A/X/Y=1, then mem_req=1 and addr_sel=0 on the next cycle.
- Stream A9,42 -> load_A on cycle 4 after FETCH entry; src_sel=0, data latch=8'h42, pc_inc pulsed twice.
- Stream AD,34,12, mem returns 8'h7F at {12,34} -> addr_sel=2 with oph=8'h12 and opl=8'h34 in READ; load_A with latch 8'h7F in cycle 6.
- Opcode AA -> WB 2 cycles after ack with src_sel=1 and load_X=1. Opcode 98 -> src_sel=3 and load_A=1.
- Opcode 8'hFF -> illegal=1, no load strobes, next FETCH begins; illegal stays 1 after a following valid A0,05.
- mem_ack withheld for 15 cycles in READ -> bus_err=1 and state FAULT; pulling reset_n low mid-OPER_HI -> all outputs 0 asynchronously and the next instruction starts cleanly.
